mux_nch_stream: RTL and testbench

//  Parametrised N-channel, W-bit registered stream multiplexer; successor to the 2:1 combinational mux.

---
 rtl/mux_pkg.sv | 11 +
 rtl/mux_nch_stream_if.sv | 34 +++
 rtl/mux_rr_sel.sv | 81 ++++++++
 rtl/mux_nch_stream.sv | 90 +++++++++
 tb/tb_mux_nch_stream.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/mux_pkg.sv
// Shared constants for the N-channel stream multiplexer.
//   MODE_FIXED : channel picked by the external select
//   MODE_RR    : automatic round-robin scan with a dwell count per channel
//   MODE_PAUSE : no captures; 2'd3 decodes as PAUSE as well
package mux_pkg;

    localparam logic [1:0] MODE_FIXED = 2'd0;
    localparam logic [1:0] MODE_RR    = 2'd1;
    localparam logic [1:0] MODE_PAUSE = 2'd2;

endpackage

// File: rtl/mux_nch_stream_if.sv
// Stream bundle between N valid/ready producers, the multiplexer and one consumer.
//   in_data   N*W   channel i occupies [i*W +: W]
//   in_valid  N     per-channel valid
//   in_ready  N     per-channel ready, driven by the mux
//   out_data  W     registered output data
//   out_ch    SELW  channel tag of out_data
//   out_valid 1     output stage full
//   out_ready 1     consumer accepts
// master: producer/consumer side. slave: the multiplexer.
interface mux_nch_stream_if #(
    parameter int unsigned N    = 4,
    parameter int unsigned W    = 8,
    localparam int unsigned SELW = $clog2(N)
);

    logic [N*W-1:0]  in_data;
    logic [N-1:0]    in_valid;
    logic [N-1:0]    in_ready;
    logic [W-1:0]    out_data;
    logic [SELW-1:0] out_ch;
    logic            out_valid;
    logic            out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_ch, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_ch, out_valid
    );

endinterface

// File: rtl/mux_rr_sel.sv
// Channel pointer and dwell counter for the stream multiplexer.
//   clk, rst     clock, synchronous active-high reset
//   mode_i       FIXED / RR / PAUSE
//   sel_i        external select, followed in FIXED when in range
//   capture_i    a beat is taken from cur_sel_o this cycle
//   cur_valid_i  in_valid of the currently selected channel
//   cur_sel_o    currently selected channel
module mux_rr_sel #(
    parameter int unsigned N     = 4,
    parameter int unsigned DWELL = 1,
    localparam int unsigned SELW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      mode_i,
    input  logic [SELW-1:0] sel_i,
    input  logic            capture_i,
    input  logic            cur_valid_i,
    output logic [SELW-1:0] cur_sel_o
);
    import mux_pkg::*;

    localparam int unsigned     CNTW     = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(DWELL - 1);
    localparam logic [SELW-1:0] SEL_LAST = SELW'(N - 1);

    logic [SELW-1:0] sel_q, sel_d, sel_next;
    logic [CNTW-1:0] cnt_q, cnt_d, cnt_cur;
    logic            rr_q, rr_d;

    always_comb begin
        sel_next = (sel_q == SEL_LAST) ? '0 : sel_q + 1'b1;
        // A fresh entry into RR always starts with an empty dwell count.
        cnt_cur  = rr_q ? cnt_q : '0;
        sel_d    = sel_q;
        cnt_d    = cnt_q;
        rr_d     = (mode_i == MODE_RR);
        case (mode_i)
            MODE_FIXED: begin
                cnt_d = '0;
                if (32'(sel_i) < N) begin
                    sel_d = sel_i;
                end
            end
            MODE_RR: begin
                if (capture_i) begin
                    if (cnt_cur == CNT_LAST) begin
                        sel_d = sel_next;
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_cur + 1'b1;
                    end
                end else if (!cur_valid_i) begin
                    // Idle channel: move on after a single cycle.
                    sel_d = sel_next;
                    cnt_d = '0;
                end else begin
                    // Backpressure: stay on this channel.
                    cnt_d = cnt_cur;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q <= '0;
            cnt_q <= '0;
            rr_q  <= 1'b0;
        end else begin
            sel_q <= sel_d;
            cnt_q <= cnt_d;
            rr_q  <= rr_d;
        end
    end

    assign cur_sel_o = sel_q;

endmodule

// File: rtl/mux_nch_stream.sv
// N-channel, W-bit registered stream multiplexer.
//   clk, rst  clock, synchronous active-high reset
//   mode_i    0=FIXED, 1=ROUND_ROBIN, 2/3=PAUSE
//   sel_i     channel select for FIXED mode
//   bus       stream bundle (inputs, per-channel ready, registered output stage)
//   cur_sel   currently selected channel
module mux_nch_stream #(
    parameter int unsigned N     = 4,
    parameter int unsigned W     = 8,
    parameter int unsigned DWELL = 1,
    localparam int unsigned SELW = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode_i,
    input  logic [SELW-1:0]  sel_i,
    mux_nch_stream_if.slave  bus,
    output logic [SELW-1:0]  cur_sel
);
    import mux_pkg::*;

    logic            load, pause, capture, cur_valid;
    logic [N-1:0]    in_ready;
    logic [W-1:0]    cur_data;
    logic [W-1:0]    out_data_q, out_data_d;
    logic [SELW-1:0] out_ch_q, out_ch_d;
    logic            out_valid_q, out_valid_d;

    mux_rr_sel #(
        .N     (N),
        .DWELL (DWELL)
    ) u_rr_sel (
        .clk         (clk),
        .rst         (rst),
        .mode_i      (mode_i),
        .sel_i       (sel_i),
        .capture_i   (capture),
        .cur_valid_i (cur_valid),
        .cur_sel_o   (cur_sel)
    );

    assign load  = !out_valid_q || bus.out_ready;
    assign pause = (mode_i != MODE_FIXED) && (mode_i != MODE_RR);

    always_comb begin
        cur_data  = '0;
        cur_valid = 1'b0;
        in_ready  = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (cur_sel == SELW'(i)) begin
                cur_data    = bus.in_data[i*W +: W];
                cur_valid   = bus.in_valid[i];
                in_ready[i] = load && !pause && !rst;
            end
        end
    end

    assign capture      = cur_valid && (|in_ready);
    assign bus.in_ready = in_ready;

    always_comb begin
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        if (capture) begin
            out_data_d  = cur_data;
            out_ch_d    = cur_sel;
            out_valid_d = 1'b1;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_ch    = out_ch_q;
    assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_nch_stream.sv
// Directed bench: dut1 N=4 DWELL=1, dut2 N=4 DWELL=2, dut3 N=3 for out-of-range select.
module tb_mux_nch_stream;
    import mux_pkg::*;

    logic       clk;
    logic       rst;
    logic [1:0] mode1, mode2, mode3;
    logic [1:0] sel1, sel2, sel3;
    logic [1:0] cur_sel1, cur_sel2, cur_sel3;

    int n_assert = 0;
    int n_fail   = 0;

    // dut2 expectations per cycle of the DWELL=2 scan (ch1, ch3 valid)
    int exp_v [8] = '{0, 1, 1, 0, 1, 1, 0, 1};
    int exp_c [8] = '{0, 1, 1, 0, 3, 3, 0, 1};

    mux_nch_stream_if #(.N(4), .W(8)) bus1 ();
    mux_nch_stream_if #(.N(4), .W(8)) bus2 ();
    mux_nch_stream_if #(.N(3), .W(8)) bus3 ();

    mux_nch_stream #(.N(4), .W(8), .DWELL(1)) dut1 (
        .clk(clk), .rst(rst), .mode_i(mode1), .sel_i(sel1), .bus(bus1), .cur_sel(cur_sel1)
    );
    mux_nch_stream #(.N(4), .W(8), .DWELL(2)) dut2 (
        .clk(clk), .rst(rst), .mode_i(mode2), .sel_i(sel2), .bus(bus2), .cur_sel(cur_sel2)
    );
    mux_nch_stream #(.N(3), .W(8), .DWELL(1)) dut3 (
        .clk(clk), .rst(rst), .mode_i(mode3), .sel_i(sel3), .bus(bus3), .cur_sel(cur_sel3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst   = 1'b1;
        mode1 = MODE_FIXED;
        mode2 = MODE_FIXED;
        mode3 = MODE_FIXED;
        sel1  = 2'd0;
        sel2  = 2'd0;
        sel3  = 2'd0;
        bus1.in_valid  = 4'b1111;
        bus1.in_data   = '0;
        bus1.out_ready = 1'b1;
        bus2.in_valid  = 4'b0000;
        bus2.in_data   = '0;
        bus2.out_ready = 1'b1;
        bus3.in_valid  = 3'b000;
        bus3.in_data   = '0;
        bus3.out_ready = 1'b1;

        // Reset held two cycles with all channels valid
        tick();
        tick();
        chk("rst_in_ready", 32'(bus1.in_ready), 32'h0);
        chk("rst_out_valid", 32'(bus1.out_valid), 32'h0);
        chk("rst_out_data", 32'(bus1.out_data), 32'h0);
        chk("rst_cur_sel", 32'(cur_sel1), 32'h0);

        // FIXED sel=2, only ch2 valid
        rst = 1'b0;
        sel1 = 2'd2;
        bus1.in_valid = 4'b0100;
        bus1.in_data  = {8'h33, 8'hA5, 8'h11, 8'h00};
        tick();
        chk("fix_cur_sel", 32'(cur_sel1), 32'h2);
        chk("fix_no_beat", 32'(bus1.out_valid), 32'h0);
        chk("fix_in_ready", 32'(bus1.in_ready), 32'h4);
        tick();
        chk("fix_data0", 32'(bus1.out_data), 32'hA5);
        chk("fix_ch0", 32'(bus1.out_ch), 32'h2);
        chk("fix_valid0", 32'(bus1.out_valid), 32'h1);
        bus1.in_data[23:16] = 8'h5A;
        tick();
        chk("fix_data1", 32'(bus1.out_data), 32'h5A);
        chk("fix_valid1", 32'(bus1.out_valid), 32'h1);

        // Backpressure for three cycles
        bus1.out_ready = 1'b0;
        bus1.in_data[23:16] = 8'h77;
        #1;
        chk("bp_in_ready", 32'(bus1.in_ready), 32'h0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("bp_hold_data", 32'(bus1.out_data), 32'h5A);
            chk("bp_hold_valid", 32'(bus1.out_valid), 32'h1);
        end
        bus1.out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(bus1.in_ready), 32'h4);
        tick();
        chk("bp_next_data", 32'(bus1.out_data), 32'h77);

        // Round robin DWELL=1, all valid; first park on ch0 in FIXED
        bus1.in_valid = 4'b1111;
        bus1.in_data  = {8'h13, 8'h12, 8'h11, 8'h10};
        sel1 = 2'd0;
        tick();
        chk("rr_start_sel", 32'(cur_sel1), 32'h0);
        mode1 = MODE_RR;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("rr1_ch", 32'(bus1.out_ch), 32'(k % 4));
            chk("rr1_data", 32'(bus1.out_data), 32'h10 + 32'(k % 4));
        end
        chk("rr1_sel_after", 32'(cur_sel1), 32'h1);

        // PAUSE with a full output stage: drains, nothing new, select held
        mode1 = MODE_PAUSE;
        #1;
        chk("pause_in_ready", 32'(bus1.in_ready), 32'h0);
        tick();
        chk("pause_drain", 32'(bus1.out_valid), 32'h0);
        chk("pause_sel", 32'(cur_sel1), 32'h1);
        tick();
        chk("pause_idle", 32'(bus1.out_valid), 32'h0);
        chk("pause_sel2", 32'(cur_sel1), 32'h1);

        // Round robin DWELL=2, only ch1 and ch3 valid
        bus2.in_valid = 4'b1010;
        bus2.in_data  = {8'h23, 8'h00, 8'h21, 8'h00};
        mode2 = MODE_RR;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("rr2_valid", 32'(bus2.out_valid), 32'(exp_v[k]));
            if (exp_v[k] != 0) begin
                chk("rr2_ch", 32'(bus2.out_ch), 32'(exp_c[k]));
                chk("rr2_data", 32'(bus2.out_data), (exp_c[k] == 1) ? 32'h21 : 32'h23);
            end
        end

        // Out-of-range select on a 3-channel instance is ignored
        sel3 = 2'd2;
        tick();
        chk("oor_sel_valid", 32'(cur_sel3), 32'h2);
        sel3 = 2'd3;
        tick();
        chk("oor_sel_held", 32'(cur_sel3), 32'h2);

        // Reset with a pending beat drops it
        mode1 = MODE_FIXED;
        sel1  = 2'd0;
        bus1.out_ready = 1'b0;
        tick();
        chk("mid_beat_valid", 32'(bus1.out_valid), 32'h1);
        chk("mid_beat_data", 32'(bus1.out_data), 32'h11);
        rst = 1'b1;
        tick();
        chk("mid_rst_valid", 32'(bus1.out_valid), 32'h0);
        chk("mid_rst_ready", 32'(bus1.in_ready), 32'h0);
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
